// File: rtl/conv_pkg.sv
// Shared types and default geometry for the streaming 2-D convolution core.
package conv_pkg;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_READY,
        S_RUN
    } conv_state_t;

    localparam int unsigned CONV_KERNEL_SIZE = 5;
    localparam int unsigned CONV_DATA_BW     = 8;
    localparam int unsigned CONV_WEIGHT_BW   = 8;
    localparam int unsigned CONV_ADDR_BW     = 5;
    localparam int unsigned CONV_SUM_BW      = 16;
    localparam int unsigned CONV_DATA_SIZE   = 32;

    localparam int unsigned NUM_TAPS      = CONV_KERNEL_SIZE ** 2;
    localparam int unsigned ACC_BW        = CONV_DATA_BW + CONV_WEIGHT_BW + 1 + $clog2(NUM_TAPS);
    localparam int          SAT_MAX       = 2 ** (CONV_SUM_BW - 1) - 1;
    localparam int          SAT_MIN       = -(2 ** (CONV_SUM_BW - 1));
    localparam int unsigned OUT_PER_FRAME = (CONV_DATA_SIZE - CONV_KERNEL_SIZE + 1) ** 2;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: a DEPTH-deep shift register that advances only on accepted pixels.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = CONV_DATA_SIZE,
    parameter int unsigned WIDTH = CONV_DATA_BW
) (
    input  logic             ACLK,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge ACLK) begin
        if (i_en) begin
            mem[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign o_q = mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream_core.sv
// Streaming valid-region 2-D convolution with saturated output, 3-cycle latency.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv2d_stream_core
    import conv_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = CONV_KERNEL_SIZE,
    parameter int unsigned DATA_BW     = CONV_DATA_BW,
    parameter int unsigned WEIGHT_BW   = CONV_WEIGHT_BW,
    parameter int unsigned ADDR_BW     = CONV_ADDR_BW,
    parameter int unsigned SUM_BW      = CONV_SUM_BW,
    parameter int unsigned DATA_SIZE   = CONV_DATA_SIZE
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 i_w_valid,
    input  logic [WEIGHT_BW-1:0] i_w,
    input  logic [ADDR_BW-1:0]   i_addr,
    input  logic                 i_valid,
    input  logic [DATA_BW-1:0]   i_x,
    output logic [SUM_BW-1:0]    o_y,
    output logic                 o_valid,
    output logic                 o_frame_done
);

    localparam int unsigned TAPS    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned PROD_BW = DATA_BW + WEIGHT_BW + 1;
    localparam int unsigned ACC_W   = PROD_BW + $clog2(TAPS);
    localparam int unsigned CNT_BW  = $clog2(DATA_SIZE);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (SUM_BW - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (SUM_BW - 1)));

    conv_state_t state, state_nx;
    logic        accept, reload, frame_last, gen;
    logic [CNT_BW-1:0] row, col;

    logic signed [WEIGHT_BW-1:0] weight [TAPS];
    logic [DATA_BW-1:0] win [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_BW-1:0] lb_in  [KERNEL_SIZE-1];
    logic [DATA_BW-1:0] lb_out [KERNEL_SIZE-1];
    logic [DATA_BW-1:0] col_in [KERNEL_SIZE];
    logic signed [PROD_BW-1:0] prod [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [SUM_BW-1:0]         y_nx;
    logic v1, l1, v2, l2;

    assign reload     = i_w_valid && (i_addr == '0);
    assign frame_last = (32'(row) == DATA_SIZE - 1) && (32'(col) == DATA_SIZE - 1);
    assign gen        = accept && (32'(row) >= KERNEL_SIZE - 1) && (32'(col) >= KERNEL_SIZE - 1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= S_EMPTY;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (reload) begin
            state_nx = S_LOAD;
        end else begin
            case (state)
                S_EMPTY: if (i_w_valid) state_nx = S_LOAD;
                S_LOAD:  if (i_w_valid && 32'(i_addr) == TAPS - 1) state_nx = S_READY;
                S_READY: if (i_valid && !i_w_valid) state_nx = S_RUN;
                S_RUN:   if (accept && frame_last) state_nx = S_READY;
                default: state_nx = S_EMPTY;
            endcase
        end
    end

    // A weight write in the same cycle as a pixel always drops the pixel.
    always_comb begin
        accept = 1'b0;
        if ((state == S_READY || state == S_RUN) && i_valid && !i_w_valid) accept = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            row <= '0;
            col <= '0;
        end else if (reload) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (32'(col) == DATA_SIZE - 1) begin
                col <= '0;
                row <= (32'(row) == DATA_SIZE - 1) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int unsigned k = 0; k < TAPS; k++) weight[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (i_w_valid && 32'(i_addr) == k) weight[k] <= i_w;
            end
        end
    end

    // Row KERNEL_SIZE-1 of the window is the current row; each line buffer adds one row of age.
    for (genvar j = 0; j < KERNEL_SIZE - 1; j++) begin : g_lb
        if (j == 0) begin : g_first
            assign lb_in[j] = i_x;
        end else begin : g_chain
            assign lb_in[j] = lb_out[j-1];
        end
        conv_line_buffer #(.DEPTH(DATA_SIZE), .WIDTH(DATA_BW)) u_lb (
            .ACLK (ACLK),
            .i_en (accept),
            .i_d  (lb_in[j]),
            .o_q  (lb_out[j])
        );
    end

    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_col
        if (r == KERNEL_SIZE - 1) begin : g_new
            assign col_in[r] = i_x;
        end else begin : g_old
            assign col_in[r] = lb_out[KERNEL_SIZE-2-r];
        end
    end

    always_ff @(posedge ACLK) begin
        if (accept) begin
            for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
                for (int unsigned c = 0; c < KERNEL_SIZE - 1; c++) win[r][c] <= win[r][c+1];
                win[r][KERNEL_SIZE-1] <= col_in[r];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod[k] <= PROD_BW'($signed({1'b0, win[k / KERNEL_SIZE][k % KERNEL_SIZE]}))
                     * PROD_BW'(weight[k]);
        end
    end

    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod[k]);
        if (acc > SAT_HI)      y_nx = SAT_HI[SUM_BW-1:0];
        else if (acc < SAT_LO) y_nx = SAT_LO[SUM_BW-1:0];
        else                   y_nx = acc[SUM_BW-1:0];
`ifdef CONV_RELU_EN
        if (y_nx[SUM_BW-1]) y_nx = '0;
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            v1           <= 1'b0;
            l1           <= 1'b0;
            v2           <= 1'b0;
            l2           <= 1'b0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_y          <= '0;
        end else begin
            v1           <= gen;
            l1           <= gen && frame_last;
            v2           <= v1;
            l2           <= l1;
            o_valid      <= v2;
            o_frame_done <= l2;
            if (v2) o_y <= y_nx;
        end
    end

endmodule

// File: tb/tb_conv2d_stream_core.sv
// Directed self-checking bench for conv2d_stream_core with an expected-result queue.
module tb_conv2d_stream_core;

    logic        ACLK;
    logic        ARESETn;
    logic        i_w_valid;
    logic [7:0]  i_w;
    logic [4:0]  i_addr;
    logic        i_valid;
    logic [7:0]  i_x;
    logic [15:0] o_y;
    logic        o_valid;
    logic        o_frame_done;

    conv2d_stream_core #(
        .KERNEL_SIZE(5), .DATA_BW(8), .WEIGHT_BW(8), .ADDR_BW(5), .SUM_BW(16), .DATA_SIZE(32)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .i_w_valid(i_w_valid), .i_w(i_w), .i_addr(i_addr),
        .i_valid(i_valid), .i_x(i_x), .o_y(o_y), .o_valid(o_valid), .o_frame_done(o_frame_done)
    );

    typedef struct {
        logic signed [15:0] y;
        logic               last;
    } exp_t;

    exp_t exp_q[$];
    int   checks, errors;
    int   cyc = 0;
    int   res_cnt, done_cnt, t_first, t_last, t_acc, r0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wval(input int kind, input int k);
        case (kind)
            0:       return 8'd1;
            1:       return (k == 12) ? 8'd1 : 8'd0;
            2:       return 8'd127;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [7:0] pval(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd1;
            1:       return 8'((r * 32 + c) & 255);
            default: return 8'd255;
        endcase
    endfunction

    function automatic logic signed [15:0] eval(input int kind, input int r, input int c);
        case (kind)
            0:       return 16'sd25;
            1:       return 16'(((r - 2) * 32 + (c - 2)) & 255);
            2:       return 16'sd32767;
`ifdef CONV_RELU_EN
            default: return 16'sd0;
`else
            default: return 16'h8000;
`endif
        endcase
    endfunction

    task automatic push(input logic signed [15:0] y, input logic last);
        exp_t e;
        e.y    = y;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic cycle_pix(input logic [7:0] x);
        @(negedge ACLK);
        i_w_valid = 1'b0;
        i_valid   = 1'b1;
        i_x       = x;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge ACLK);
            i_w_valid = 1'b0;
            i_valid   = 1'b0;
        end
    endtask

    task automatic write_w(input int k, input logic [7:0] v);
        @(negedge ACLK);
        i_valid   = 1'b0;
        i_w_valid = 1'b1;
        i_addr    = 5'(k);
        i_w       = v;
    endtask

    task automatic load_weights(input int kind);
        for (int k = 0; k < 25; k++) write_w(k, wval(kind, k));
        idle(1);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (o_frame_done) check("done_needs_valid", 32'(o_valid), 1);
            if (o_valid) begin
                res_cnt++;
                t_last = cyc;
                if (res_cnt == 1) t_first = cyc;
                if (o_frame_done) done_cnt++;
                check("unexpected_result", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("o_y", $signed(o_y), e.y);
                    check("o_frame_done", 32'(o_frame_done), 32'(e.last));
                end
            end
        end
    endtask

    task automatic run_frame(input int kind, input bit gaps);
        int r, c;
        res_cnt  = 0;
        done_cnt = 0;
        t_first  = 0;
        t_acc    = 0;
        for (int idx = 0; idx < 1024; idx++) begin
            r = idx / 32;
            c = idx % 32;
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            cycle_pix(pval(kind, r, c));
            if (idx == 132) t_acc = cyc;
            if (r >= 4 && c >= 4) push(eval(kind, r, c), idx == 1023);
        end
        idle(1);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle(1);
        check("result_count", res_cnt, 784);
        check("frame_done_count", done_cnt, 1);
        check("first_latency", t_first - t_acc, 3);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int r, c;
        checks    = 0;
        errors    = 0;
        res_cnt   = 0;
        done_cnt  = 0;
        ARESETn   = 1'b0;
        i_w_valid = 1'b0;
        i_w       = '0;
        i_addr    = '0;
        i_valid   = 1'b0;
        i_x       = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge ACLK);
        #1;
        check("reset_o_valid", 32'(o_valid), 0);
        check("reset_o_y", 32'(o_y), 0);
        check("reset_o_frame_done", 32'(o_frame_done), 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        for (int i = 0; i < 200; i++) cycle_pix(8'd1);
        idle(6);
        check("empty_ignores_pixels", res_cnt, 0);

        load_weights(0);
        run_frame(0, 1'b0);
        load_weights(1);
        run_frame(1, 1'b0);
        load_weights(2);
        run_frame(2, 1'b0);
        load_weights(3);
        run_frame(3, 1'b0);
        load_weights(0);
        run_frame(0, 1'b1);

        // Reload at pixel 500: the reload write coincides with pixel 500, which is dropped.
        res_cnt = 0;
        for (int idx = 0; idx < 500; idx++) begin
            r = idx / 32;
            c = idx % 32;
            cycle_pix(8'd1);
            if (r >= 4 && c >= 4) push(16'sd25, 1'b0);
        end
        @(negedge ACLK);
        i_w_valid = 1'b1;
        i_addr    = 5'd0;
        i_w       = 8'd1;
        i_valid   = 1'b1;
        i_x       = 8'd1;
        for (int k = 1; k < 25; k++) begin
            cycle_pix(8'd1);
            write_w(k, 8'd1);
        end
        check("inflight_results", res_cnt, 324);
        check("inflight_drained", exp_q.size(), 0);
        for (int i = 0; i < 132; i++) cycle_pix(8'd1);
        idle(6);
        check("no_early_output", res_cnt, 324);
        cycle_pix(8'd1);
        t_acc = cyc;
        push(16'sd25, 1'b0);
        idle(5);
        check("reload_first_result", res_cnt, 325);
        check("reload_latency", t_last - t_acc, 3);

        for (int idx = 133; idx <= 200; idx++) begin
            r = idx / 32;
            c = idx % 32;
            cycle_pix(8'd1);
            if (c >= 4) push(16'sd25, 1'b0);
        end
        check("o_y_before_reset", $signed(o_y), 25);
        #2;
        ARESETn = 1'b0;
        i_valid = 1'b0;
        #1;
        check("midreset_o_valid", 32'(o_valid), 0);
        check("midreset_o_y", 32'(o_y), 0);
        check("midreset_o_frame_done", 32'(o_frame_done), 0);
        exp_q.delete();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;

        r0 = res_cnt;
        for (int i = 0; i < 200; i++) cycle_pix(8'd1);
        for (int k = 0; k < 24; k++) begin
            write_w(k, 8'd1);
            cycle_pix(8'd1);
        end
        for (int i = 0; i < 200; i++) cycle_pix(8'd1);
        idle(6);
        check("postreset_ignored", res_cnt - r0, 0);
        write_w(24, 8'd1);
        run_frame(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
